mips_multicycle_control: RTL and testbench
==========================================

# mips_multicycle_control

Multicycle main control FSM for the MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath strobe and mux select from the current state. It stalls on a memory ready handshake, flags unsupported opcodes, and counts retired instructions. It sits between the instruction register opcode field and the shared-memory multicycle datapath. It extends the single-cycle opcode decoder with sequencing, branch, jump and addi support.

## Interface
Parameters:
- `ALUOP_W`, default 2: width of `ALUout`; encodings are zero-extended to this width (minimum 2).
- `CNT_W`, default 32: width of the retired-instruction counter.
- `EN_ADDI`, default 1: when 0, opcode 001000 is treated as illegal.
- `EN_JUMP`, default 1: when 0, opcode 000010 is treated as illegal.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 6: IR[31:26]; sampled in DECODE only.
- `mem_ready` in 1: memory completes the current access this cycle.
- `PCWrite` out 1: PC load, unconditional.
- `PCWriteCond` out 1: PC load when ALU zero (beq).
- `IorD` out 1: memory address select; 0 = PC, 1 = ALU result register.
- `MemR` out 1: memory read request.
- `MemW` out 1: memory write request.
- `IRWrite` out 1: instruction register load.
- `MemToReg` out 1: writeback select; 1 = MDR, 0 = ALU result register.
- `regDest` out 1: destination select; 0 = rd, 1 = rt.
- `RegW` out 1: register file write.
- `aluSrcA` out 1: 0 = PC, 1 = rs.
- `aluSrcB` out 2: 00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `ALUout` out ALUOP_W: 0 = add, 1 = subtract, 2 = decode by funct.
- `PCSource` out 2: 00 = ALU, 01 = ALU result register, 10 = jump target.
- `illegal` out 1: one-cycle pulse when an unsupported opcode is decoded.
- `state_o` out 4: current state, for debug.
- `retired` out CNT_W: count of completed instructions.

## Operation
States and 4-bit encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11, ILLEGAL 12. Encodings 13–15 go to FETCH on the next clock.

Any output not listed for a state is 0.

- **FETCH:** `MemR`=1, `IorD`=0, `aluSrcA`=0, `aluSrcB`=01, `ALUout`=add, `PCSource`=00.
  - `IRWrite` and `PCWrite` are asserted only when `mem_ready`=1.
  - Go to DECODE when `mem_ready`; otherwise hold.
- **DECODE:** `aluSrcA`=0, `aluSrcB`=11, `ALUout`=add (branch target precompute).
  - Next state by opcode: 000000 → EXEC; 100011 or 101011 → MEMADR; 000100 → BRANCH; 000010 → JUMP (if EN_JUMP); 001000 → ADDIEX (if EN_ADDI); anything else → ILLEGAL.
- **MEMADR:** `aluSrcA`=1, `aluSrcB`=10, `ALUout`=add. Go to MEMRD for lw, MEMWR for sw; the opcode is the one latched in DECODE.
- **MEMRD:** `MemR`=1, `IorD`=1. Hold until `mem_ready`, then go to MEMWB.
- **MEMWB:** `RegW`=1, `MemToReg`=1, `regDest`=1. Go to FETCH.
- **MEMWR:** `MemW`=1, `IorD`=1. Hold until `mem_ready`, then go to FETCH.
- **EXEC:** `aluSrcA`=1, `aluSrcB`=00, `ALUout`=funct. Go to RWB.
- **RWB:** `RegW`=1, `MemToReg`=0, `regDest`=0. Go to FETCH.
- **BRANCH:** `aluSrcA`=1, `aluSrcB`=00, `ALUout`=sub, `PCWriteCond`=1, `PCSource`=01. Go to FETCH.
- **JUMP:** `PCWrite`=1, `PCSource`=10. Go to FETCH.
- **ADDIEX:** `aluSrcA`=1, `aluSrcB`=10, `ALUout`=add. Go to ADDIWB.
- **ADDIWB:** `RegW`=1, `MemToReg`=0, `regDest`=1. Go to FETCH.
- **ILLEGAL:** `illegal`=1. Go to FETCH. Not counted as retired.

The opcode is registered internally on the DECODE cycle. Later states use that latched copy; `opcode` changes after DECODE have no effect.

`retired` increments by 1 on the clock edge that leaves MEMWB, MEMWR (with `mem_ready`), RWB, BRANCH, JUMP or ADDIWB. It wraps modulo 2^CNT_W.

## Timing
- Outputs are combinational from the state. Exception: `IRWrite` and `PCWrite` in FETCH also depend on `mem_ready`. Next state and counter update on the rising edge.
- Reset:
  - While `rst`=1, all strobes are forced to 0: `MemR`, `MemW`, `IRWrite`, `PCWrite`, `PCWriteCond`, `RegW`, `illegal`.
  - All selects read 0, `ALUout`=0, `state_o`=0, `retired`=0.
  - The first cycle after `rst` falls is FETCH.
  - `rst` takes priority over every transition, including mid-instruction and mid-stall. A pending write is abandoned, and `MemW` drops in the reset cycle.
- Latency with `mem_ready` held at 1, in cycles: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 3.
- Each stall cycle with `mem_ready`=0 adds exactly 1 cycle. Strobes stay asserted and stable throughout the stall.
- `mem_ready` is ignored in every state other than FETCH, MEMRD and MEMWR.

## Test plan
- **Reset:** hold `rst` 2 cycles mid-MEMWR with `MemW`=1 → `MemW`=0 in the reset cycle, `state_o`=0 and `retired`=0 on release, FETCH outputs on the next cycle.
- **Back-to-back:** R-type, lw, sw, beq, j, addi with `mem_ready`=1 → state sequences 0,1,6,7 / 0,1,2,3,4 / 0,1,2,5 / 0,1,8 / 0,1,9 / 0,1,10,11; `retired`=6; outputs match the Operation list each cycle.
- **Stalls:**
  - lw with `mem_ready`=0 for 3 cycles in FETCH and 2 in MEMRD → latency 10. `IRWrite` pulses exactly once, coincident with `mem_ready`. `MemR` is steady during the stall.
  - sw with `mem_ready`=0 for 4 cycles in MEMWR → `MemW` high for 5 cycles; `retired` increments once.
- **Illegal:** opcode 111111 → `illegal` high exactly 1 cycle in state 12, then FETCH; `retired` unchanged.
- **Parameters and opcode stability:**
  - With EN_JUMP=0 and EN_ADDI=0: opcodes 000010 and 001000 → ILLEGAL path.
  - With ALUOP_W=4: R-type EXEC gives `ALUout`=4'b0010.
- **Counter wrap:** CNT_W=3, 9 R-type instructions → `retired`=1. Changing `opcode` after DECODE leaves the state path unaffected.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multicycle MIPS main control FSM
// Sequences fetch/decode/execute/memory/writeback; strobes decode from state.
module mips_multicycle_control #(
  parameter int ALUOP_W = 2,
  parameter int CNT_W   = 32,
  parameter bit EN_ADDI = 1'b1,
  parameter bit EN_JUMP = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemR,
  output logic               MemW,
  output logic               IRWrite,
  output logic               MemToReg,
  output logic               regDest,
  output logic               RegW,
  output logic               aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic [ALUOP_W-1:0] ALUout,
  output logic [1:0]         PCSource,
  output logic               illegal,
  output logic [3:0]         state_o,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB    = 4'd7,
    S_BRANCH  = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = '0;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);

  state_t             r_state;
  logic [5:0]         r_op;
  logic [CNT_W-1:0]   r_retired;
  state_t             w_dec_state;

  always_comb begin
    w_dec_state = S_ILLEGAL;
    case (opcode)
      OP_RTYPE:     w_dec_state = S_EXEC;
      OP_LW, OP_SW: w_dec_state = S_MEMADR;
      OP_BEQ:       w_dec_state = S_BRANCH;
      OP_J:         if (EN_JUMP) w_dec_state = S_JUMP;
      OP_ADDI:      if (EN_ADDI) w_dec_state = S_ADDIEX;
      default:      w_dec_state = S_ILLEGAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_op      <= '0;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_FETCH:  if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_op    <= opcode;
          r_state <= w_dec_state;
        end
        S_MEMADR: r_state <= (r_op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) r_state <= S_MEMWB;
        S_MEMWR: if (mem_ready) begin
          r_state   <= S_FETCH;
          r_retired <= r_retired + CNT_W'(1);
        end
        S_EXEC:   r_state <= S_RWB;
        S_ADDIEX: r_state <= S_ADDIWB;
        S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
          r_state   <= S_FETCH;
          r_retired <= r_retired + CNT_W'(1);
        end
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // Reset masks every output so a pending memory write drops in the reset cycle.
  always_comb begin
    PCWrite = 1'b0; PCWriteCond = 1'b0; IorD = 1'b0; MemR = 1'b0; MemW = 1'b0;
    IRWrite = 1'b0; MemToReg = 1'b0; regDest = 1'b0; RegW = 1'b0; aluSrcA = 1'b0;
    aluSrcB = 2'b00; ALUout = ALU_ADD; PCSource = 2'b00; illegal = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          MemR = 1'b1; aluSrcB = 2'b01;
          IRWrite = mem_ready; PCWrite = mem_ready;
        end
        S_DECODE: aluSrcB = 2'b11;
        S_MEMADR, S_ADDIEX: begin aluSrcA = 1'b1; aluSrcB = 2'b10; end
        S_MEMRD:  begin MemR = 1'b1; IorD = 1'b1; end
        S_MEMWB:  begin RegW = 1'b1; MemToReg = 1'b1; regDest = 1'b1; end
        S_MEMWR:  begin MemW = 1'b1; IorD = 1'b1; end
        S_EXEC:   begin aluSrcA = 1'b1; ALUout = ALU_FUNCT; end
        S_RWB:    RegW = 1'b1;
        S_BRANCH: begin
          aluSrcA = 1'b1; ALUout = ALU_SUB; PCWriteCond = 1'b1; PCSource = 2'b01;
        end
        S_JUMP:   begin PCWrite = 1'b1; PCSource = 2'b10; end
        S_ADDIWB: begin RegW = 1'b1; regDest = 1'b1; end
        S_ILLEGAL: illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign state_o = rst ? 4'd0 : r_state;
  assign retired = rst ? '0 : r_retired;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - randomized bench for mips_multicycle_control
// Two instances: default parameters, and ALUOP_W=4/CNT_W=3 with jump and addi disabled.
module tb_mips_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v [2];
  logic [5:0] op_v  [2];
  logic       mr_v  [2];

  logic [1:0]  d0_alu, d0_pcs, d0_srcb;
  logic [31:0] d0_ret;
  logic [3:0]  d0_st;
  logic d0_pcw, d0_pcwc, d0_iord, d0_memr, d0_memw, d0_irw, d0_m2r, d0_rdst, d0_regw, d0_srca, d0_ill;
  logic [3:0]  d1_alu;
  logic [1:0]  d1_pcs, d1_srcb;
  logic [2:0]  d1_ret;
  logic [3:0]  d1_st;
  logic d1_pcw, d1_pcwc, d1_iord, d1_memr, d1_memw, d1_irw, d1_m2r, d1_rdst, d1_regw, d1_srca, d1_ill;

  mips_multicycle_control u_d0 (
    .clk(clk), .rst(rst_v[0]), .opcode(op_v[0]), .mem_ready(mr_v[0]),
    .PCWrite(d0_pcw), .PCWriteCond(d0_pcwc), .IorD(d0_iord), .MemR(d0_memr), .MemW(d0_memw),
    .IRWrite(d0_irw), .MemToReg(d0_m2r), .regDest(d0_rdst), .RegW(d0_regw), .aluSrcA(d0_srca),
    .aluSrcB(d0_srcb), .ALUout(d0_alu), .PCSource(d0_pcs), .illegal(d0_ill), .state_o(d0_st),
    .retired(d0_ret)
  );

  mips_multicycle_control #(.ALUOP_W(4), .CNT_W(3), .EN_ADDI(1'b0), .EN_JUMP(1'b0)) u_d1 (
    .clk(clk), .rst(rst_v[1]), .opcode(op_v[1]), .mem_ready(mr_v[1]),
    .PCWrite(d1_pcw), .PCWriteCond(d1_pcwc), .IorD(d1_iord), .MemR(d1_memr), .MemW(d1_memw),
    .IRWrite(d1_irw), .MemToReg(d1_m2r), .regDest(d1_rdst), .RegW(d1_regw), .aluSrcA(d1_srca),
    .aluSrcB(d1_srcb), .ALUout(d1_alu), .PCSource(d1_pcs), .illegal(d1_ill), .state_o(d1_st),
    .retired(d1_ret)
  );

  // Observation bus: state, ALU op (4b), PCSource, aluSrcB, then single-bit strobes.
  logic [22:0] obs [2];
  logic [31:0] ret [2];
  assign obs[0] = {d0_st, 2'b00, d0_alu, d0_pcs, d0_srcb, d0_srca, d0_rdst, d0_regw, d0_m2r,
                   d0_irw, d0_memw, d0_memr, d0_iord, d0_pcwc, d0_pcw, d0_ill};
  assign obs[1] = {d1_st, d1_alu, d1_pcs, d1_srcb, d1_srca, d1_rdst, d1_regw, d1_m2r,
                   d1_irw, d1_memw, d1_memr, d1_iord, d1_pcwc, d1_pcw, d1_ill};
  assign ret[0] = d0_ret;
  assign ret[1] = {29'd0, d1_ret};

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned exp_cnt [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [22:0] exp_vec(input int st, input bit mr);
    logic [3:0] alu = 4'd0;
    logic [1:0] pcs = 2'd0, srcb = 2'd0;
    bit srca = 0, rdst = 0, regw = 0, m2r = 0, irw = 0, memw = 0;
    bit memr = 0, iord = 0, pcwc = 0, pcw = 0, ill = 0;
    case (st)
      0:  begin memr = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      1:  srcb = 2'b11;
      2, 10: begin srca = 1; srcb = 2'b10; end
      3:  begin memr = 1; iord = 1; end
      4:  begin regw = 1; m2r = 1; rdst = 1; end
      5:  begin memw = 1; iord = 1; end
      6:  begin srca = 1; alu = 4'd2; end
      7:  regw = 1;
      8:  begin srca = 1; alu = 4'd1; pcwc = 1; pcs = 2'b01; end
      9:  begin pcw = 1; pcs = 2'b10; end
      11: begin regw = 1; rdst = 1; end
      12: ill = 1;
      default: ;
    endcase
    return {4'(st), alu, pcs, srcb, srca, rdst, regw, m2r, irw, memw, memr, iord, pcwc, pcw, ill};
  endfunction

  function automatic logic [31:0] cnt_mod(input int k);
    return (k == 1) ? 32'(exp_cnt[k] % 8) : 32'(exp_cnt[k]);
  endfunction

  task automatic do_reset(input int k, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      rst_v[k] = 1'b1; mr_v[k] = 1'b0; op_v[k] = 6'($urandom);
      #3;
      check($sformatf("d%0d reset outputs", k), 32'(obs[k]), 32'd0);
      check($sformatf("d%0d reset MemW", k), 32'(obs[k][5]), 32'd0);
      check($sformatf("d%0d reset retired", k), ret[k], 32'd0);
    end
    exp_cnt[k] = 0;
  endtask

  // Instruction expressed as its sequence of (state, mem_ready) cycles; cut>0 abandons it early.
  task automatic run_instr(input int k, input logic [5:0] op, input int fst, input int mst, input int cut);
    int sts[$];
    bit mrs[$];
    int n;
    bit en = (k == 0);
    for (int i = 0; i < fst; i++) begin sts.push_back(0); mrs.push_back(1'b0); end
    sts.push_back(0); mrs.push_back(1'b1);
    sts.push_back(1); mrs.push_back(1'($urandom));
    case (op)
      OP_R:   begin sts.push_back(6); sts.push_back(7); end
      OP_LW: begin
        sts.push_back(2); mrs.push_back(1'($urandom));
        for (int i = 0; i < mst; i++) begin sts.push_back(3); mrs.push_back(1'b0); end
        sts.push_back(3); mrs.push_back(1'b1); sts.push_back(4);
      end
      OP_SW: begin
        sts.push_back(2); mrs.push_back(1'($urandom));
        for (int i = 0; i < mst; i++) begin sts.push_back(5); mrs.push_back(1'b0); end
        sts.push_back(5); mrs.push_back(1'b1);
      end
      OP_BEQ:  sts.push_back(8);
      OP_J:    sts.push_back(en ? 9 : 12);
      OP_ADDI: if (en) begin sts.push_back(10); sts.push_back(11); end else sts.push_back(12);
      default: sts.push_back(12);
    endcase
    while (mrs.size() < sts.size()) mrs.push_back(1'($urandom));
    n = (cut > 0) ? cut : sts.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst_v[k] = 1'b0; mr_v[k] = mrs[i];
      op_v[k] = (sts[i] == 1) ? op : 6'($urandom);
      #3;
      check($sformatf("d%0d op%02h cyc%0d outputs", k, op, i), 32'(obs[k]), 32'(exp_vec(sts[i], mrs[i])));
      check($sformatf("d%0d op%02h cyc%0d retired", k, op, i), ret[k], cnt_mod(k));
    end
    if (cut == 0 && sts[sts.size()-1] != 12) exp_cnt[k]++;
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] tbl [7] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, 6'b111111};
    int idx = $urandom_range(0, 7);
    return (idx == 7) ? 6'($urandom) : tbl[idx];
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin rst_v[k] = 1'b1; op_v[k] = '0; mr_v[k] = 1'b0; exp_cnt[k] = 0; end

    do_reset(0, 2);
    run_instr(0, OP_R, 0, 0, 0);
    run_instr(0, OP_LW, 0, 0, 0);
    run_instr(0, OP_SW, 0, 0, 0);
    run_instr(0, OP_BEQ, 0, 0, 0);
    run_instr(0, OP_J, 0, 0, 0);
    run_instr(0, OP_ADDI, 0, 0, 0);
    @(posedge clk); #1; mr_v[0] = 1'b0; #3;
    check("b2b retired six", ret[0], 32'd6);
    run_instr(0, OP_LW, 3, 2, 0);
    run_instr(0, OP_SW, 0, 4, 0);
    run_instr(0, 6'b111111, 0, 0, 0);
    for (int i = 0; i < 150; i++) run_instr(0, rand_op(), $urandom_range(0, 2), $urandom_range(0, 3), 0);
    run_instr(0, OP_SW, 0, 10, 5);
    do_reset(0, 2);
    run_instr(0, OP_R, 0, 0, 0);
    rst_v[0] = 1'b1;

    do_reset(1, 2);
    run_instr(1, OP_J, 0, 0, 0);
    run_instr(1, OP_ADDI, 1, 0, 0);
    do_reset(1, 1);
    for (int i = 0; i < 9; i++) run_instr(1, OP_R, 0, 0, 0);
    @(posedge clk); #1; mr_v[1] = 1'b0; #3;
    check("wrap nine rtype", ret[1], 32'd1);
    for (int i = 0; i < 60; i++) run_instr(1, rand_op(), $urandom_range(0, 2), $urandom_range(0, 3), 0);
    rst_v[1] = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
